light_frame_sender: RTL and testbench

LIGHT_FRAME_SENDER -- requirements
Module: light_frame_sender

---
 rtl/light_frame_sender_pkg.sv | 15 +
 rtl/light_frame_sender_spi_byte_tx.sv | 54 +++++
 rtl/light_frame_sender.sv | 155 +++++++++++++++
 tb/tb_light_frame_sender.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/light_frame_sender_pkg.sv
// light_frame_sender_pkg: shared FSM encoding, byte-order constants and defaults
package light_frame_sender_pkg;
  localparam int PIXEL_COUNT_DEF = 150;
  localparam int UNIVERSES_DEF = 16;
  localparam int ACK_TIMEOUT = 1024;
  localparam logic [1:0] BLUE = 2'd0;
  localparam logic [1:0] GREEN = 2'd1;
  localparam logic [1:0] RED = 2'd2;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD, GAP} state_t;
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;
endpackage

// File: rtl/light_frame_sender_spi_byte_tx.sv
// spi_byte_tx: SPI mode-0 byte shifter, MSB first
// Ports: clk, rst (sync, active high); load/tx_byte start a byte and restart the
// timing; sck idles low; mosi is the current bit; byte_done is high on the last
// cycle of the final high half, so a load on that cycle lands on the falling edge.
// After load: SCK_HALF cycles low, then 8 x (SCK_HALF high, SCK_HALF low) with the
// last low half left to the next load or to the caller.
module spi_byte_tx
  import light_frame_sender_pkg::*;
#(
  parameter int SCK_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       sck,
  output logic       mosi,
  output logic       byte_done
);
  localparam int HW = $clog2(SCK_HALF);
  logic [7:0] sreg;
  logic [2:0] bits;
  logic [HW-1:0] cnt;
  logic active;
  logic half_end;
  assign half_end = active && cnt == HW'(SCK_HALF - 1);
  assign byte_done = half_end && sck && bits == 3'd7;
  assign mosi = sreg[7];
  always_ff @(posedge clk)
    if (rst) begin
      sreg <= '0;
      bits <= '0;
      cnt <= '0;
      active <= 1'b0;
      sck <= 1'b0;
    end else if (load) begin
      sreg <= tx_byte;
      bits <= '0;
      cnt <= '0;
      active <= 1'b1;
      sck <= 1'b0;
    end else if (active) begin
      cnt <= half_end ? '0 : cnt + 1'b1;
      if (half_end) begin
        sck <= !sck;
        if (sck) begin
          // data advances only on a falling edge; the last bit is held
          active <= bits != 3'd7;
          bits <= bits + 1'b1;
          sreg <= bits != 3'd7 ? {sreg[6:0], 1'b0} : sreg;
        end
      end
    end
endmodule

// File: rtl/light_frame_sender.sv
// light_frame_sender: streams one universe frame (header + B,G,R per pixel) over SPI
// Ports: clk, rst (sync, active high); start/universe request a frame; busy, done,
// err status; pix_rd/pix_addr read pixels, pix_blue/green/red return one cycle
// later; sender_cs/sck/mosi drive the SPI link; sender_done is the per-byte ack.
// Option: define LIGHT_SENDER_ACK_EN to pace bytes on sender_done with a timeout.
module light_frame_sender
  import light_frame_sender_pkg::*;
#(
  parameter int PIXEL_COUNT = PIXEL_COUNT_DEF,
  parameter int UNIVERSES = UNIVERSES_DEF,
  parameter int SCK_HALF = 4,
  parameter int CS_GAP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] universe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] pix_addr,
  output logic       pix_rd,
  input  logic [7:0] pix_blue,
  input  logic [7:0] pix_green,
  input  logic [7:0] pix_red,
  output logic       sender_cs,
  output logic       sender_sck,
  output logic       sender_mosi,
  input  logic       sender_done
);
  localparam int NBYTES = 1 + 3 * PIXEL_COUNT;
  localparam int BW = $clog2(NBYTES);
  localparam int PW = PIXEL_COUNT > 1 ? $clog2(PIXEL_COUNT) : 1;
  localparam int TBASE = CS_GAP > SCK_HALF ? CS_GAP : SCK_HALF;
`ifdef LIGHT_SENDER_ACK_EN
  localparam int TMAX = TBASE > ACK_TIMEOUT + 1 ? TBASE : ACK_TIMEOUT + 1;
`else
  localparam int TMAX = TBASE;
`endif
  localparam int TW = $clog2(TMAX);
  state_t state, nxt;
  logic [TW-1:0] tmr;
  logic [BW-1:0] byte_cnt;
  logic [1:0] color, nxt_color;
  logic [PW-1:0] pix;
  pixel_t hold;
  logic rd_d;
  logic accept, reject, load, adv, fetch, fin, tout;
  logic tmr_end, gap_end, last, pix_last, byte_done;
  logic [7:0] tx_byte, fetch_addr;
  assign busy = state != IDLE;
  assign accept = state == IDLE && start && 32'(universe) < UNIVERSES;
  assign reject = state == IDLE && start && !(32'(universe) < UNIVERSES);
  assign tmr_end = tmr == TW'(SCK_HALF - 1);
  assign gap_end = tmr == TW'(CS_GAP - 1);
  assign last = byte_cnt == BW'(NBYTES - 1);
  assign pix_last = pix == PW'(PIXEL_COUNT - 1);
  assign adv = load && state != IDLE;
  // byte_cnt/color describe the byte on the wire; the next one follows B,G,R order
  assign nxt_color = (byte_cnt == '0 || color == RED) ? BLUE : color + 2'd1;
  assign tx_byte = state == IDLE ? universe :
                   (byte_cnt == '0 || color == RED) ? hold.b :
                   color == BLUE ? hold.g : hold.r;
  assign fetch_addr = state == SETUP ? 8'd0 : 8'(pix) + 8'd1;
`ifdef LIGHT_SENDER_ACK_EN
  logic [2:0] ack_sync;
  logic ack_rise;
  assign ack_rise = ack_sync[1] && !ack_sync[2];
  always_ff @(posedge clk)
    ack_sync <= rst ? 3'b000 : {ack_sync[1:0], sender_done};
`else
  logic unused_ack;
  assign unused_ack = sender_done;
`endif
  always_comb begin
    nxt = state;
    load = 1'b0;
    fetch = 1'b0;
    fin = 1'b0;
    tout = 1'b0;
    case (state)
      IDLE: begin
        nxt = accept ? SETUP : IDLE;
        load = accept;
      end
      SETUP: begin
        nxt = tmr_end ? SHIFT : SETUP;
        fetch = tmr_end;
      end
      SHIFT: begin
        nxt = byte_done ? (last ? HOLD : NEXT) : SHIFT;
`ifdef LIGHT_SENDER_ACK_EN
        load = 1'b0;
`else
        load = byte_done && !last;
`endif
      end
      NEXT: begin
`ifdef LIGHT_SENDER_ACK_EN
        // the byte loaded on the ack is red when the one just sent was green
        load = ack_rise;
        tout = !ack_rise && tmr == TW'(ACK_TIMEOUT);
        nxt = ack_rise ? SHIFT : tout ? GAP : NEXT;
        fetch = ack_rise && color == GREEN && !pix_last;
`else
        nxt = tmr_end ? SHIFT : NEXT;
        fetch = tmr_end && color == RED && !pix_last;
`endif
      end
      HOLD: begin
        nxt = tmr_end ? GAP : HOLD;
        fin = tmr_end;
      end
      GAP: nxt = gap_end ? IDLE : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      byte_cnt <= '0;
      color <= BLUE;
      pix <= '0;
      hold <= '0;
      rd_d <= 1'b0;
      sender_cs <= 1'b1;
      done <= 1'b0;
      err <= 1'b0;
      pix_rd <= 1'b0;
      pix_addr <= 8'd0;
    end else begin
      state <= nxt;
      tmr <= nxt != state ? '0 : tmr + 1'b1;
      sender_cs <= accept ? 1'b0 : (fin || tout) ? 1'b1 : sender_cs;
      done <= fin;
      err <= reject || tout;
      pix_rd <= fetch;
      pix_addr <= fetch ? fetch_addr : pix_addr;
      rd_d <= pix_rd;
      hold <= rd_d ? {pix_blue, pix_green, pix_red} : hold;
      byte_cnt <= accept ? '0 : adv ? byte_cnt + 1'b1 : byte_cnt;
      color <= accept ? BLUE : adv ? nxt_color : color;
      pix <= accept ? '0 : (adv && byte_cnt != '0 && color == RED) ? pix + 1'b1 : pix;
    end
  spi_byte_tx #(.SCK_HALF(SCK_HALF)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .tx_byte  (tx_byte),
    .sck      (sender_sck),
    .mosi     (sender_mosi),
    .byte_done(byte_done)
  );
endmodule

// File: tb/tb_light_frame_sender.sv
// tb_light_frame_sender: directed bench for light_frame_sender with a 2-pixel memory
module tb_light_frame_sender;
  logic clk = 1'b0;
  logic rst, start, sender_done;
  logic [7:0] universe;
  logic busy, done, err, pix_rd, sender_cs, sender_sck, sender_mosi;
  logic [7:0] pix_addr;
  logic [7:0] pix_blue = 8'h00, pix_green = 8'h00, pix_red = 8'h00;
  logic [7:0] mem_b [2] = '{8'h11, 8'h44};
  logic [7:0] mem_g [2] = '{8'h22, 8'h55};
  logic [7:0] mem_r [2] = '{8'h33, 8'h66};
  int total = 0, passed = 0, fails = 0;
  int done_cnt = 0, err_cnt = 0, rd_cnt = 0, addr_max = 0, falls = 0, busy_cnt = 0, mosi_bad = 0;
  int hi_min = 99, hi_max = 0, lo_min = 99, lo_max = 0, lead = 0, hi_run = 0, lo_run = 0;
  int gap_run = 0, last_gap = 0, nbits = 0;
  bit first = 1'b0;
  logic [7:0] sh = 8'h00;
  logic sck_q = 1'b0, cs_q = 1'b1, mosi_q = 1'b0;
  logic [7:0] rx [$];
  int d0, e0, f0, r0, rd0, b0;

  light_frame_sender #(.PIXEL_COUNT(2), .UNIVERSES(16), .SCK_HALF(4), .CS_GAP(16)) dut (
    .clk(clk), .rst(rst), .start(start), .universe(universe), .busy(busy), .done(done),
    .err(err), .pix_addr(pix_addr), .pix_rd(pix_rd), .pix_blue(pix_blue),
    .pix_green(pix_green), .pix_red(pix_red), .sender_cs(sender_cs),
    .sender_sck(sender_sck), .sender_mosi(sender_mosi), .sender_done(sender_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (pix_rd === 1'b1 && pix_addr < 8'd2) begin
      pix_blue <= mem_b[pix_addr[0]];
      pix_green <= mem_g[pix_addr[0]];
      pix_red <= mem_r[pix_addr[0]];
    end

  always @(negedge clk) begin
    if (cs_q === 1'b1 && sender_cs === 1'b0) begin
      falls++;
      last_gap = gap_run;
      nbits = 0;
      hi_min = 99; hi_max = 0; lo_min = 99; lo_max = 0;
      hi_run = 0; lo_run = 0; first = 1'b1;
    end
    gap_run = sender_cs === 1'b1 ? gap_run + 1 : 0;
    if (sender_cs === 1'b0) begin
      if (sender_sck === 1'b1 && sck_q === 1'b0) begin
        if (first) lead = lo_run;
        first = 1'b0;
        if (lo_run < lo_min) lo_min = lo_run;
        if (lo_run > lo_max) lo_max = lo_run;
        if (sender_mosi !== mosi_q) mosi_bad++;
        sh = {sh[6:0], sender_mosi};
        nbits++;
        if (nbits == 8) begin
          rx.push_back(sh);
          nbits = 0;
        end
        lo_run = 0;
      end
      if (sender_sck === 1'b0 && sck_q === 1'b1) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      if (sender_sck === 1'b1) hi_run++;
      else lo_run++;
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (pix_rd === 1'b1) begin
      rd_cnt++;
      if (int'(pix_addr) > addr_max) addr_max = int'(pix_addr);
    end
    sck_q = sender_sck;
    cs_q = sender_cs;
    mosi_q = sender_mosi;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] u);
    @(negedge clk);
    start = 1'b1;
    universe = u;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [55:0] pack7(input int base);
    logic [55:0] v = '0;
    for (int i = 0; i < 7; i++) v = {v[47:0], (base + i < rx.size()) ? rx[base + i] : 8'h00};
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    start = 1'b0;
    universe = 8'd0;
    sender_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(sender_cs), 64'd1);
    check("rst_sck", 64'(sender_sck), 64'd0);
    check("rst_mosi", 64'(sender_mosi), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_pix_rd", 64'(pix_rd), 64'd0);
    check("rst_pix_addr", 64'(pix_addr), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
`ifdef LIGHT_SENDER_ACK_EN
    d0 = done_cnt; e0 = err_cnt;
    send(8'd5);
    for (int i = 0; i < 3000 && err_cnt == e0; i++) @(negedge clk);
    check("ack_timeout_err", 64'(err_cnt - e0), 64'd1);
    check("ack_timeout_cs", 64'(sender_cs), 64'd1);
    repeat (30) @(negedge clk);
    check("ack_timeout_done", 64'(done_cnt - d0), 64'd0);
    check("ack_timeout_busy", 64'(busy), 64'd0);
`else
    d0 = done_cnt; e0 = err_cnt; r0 = rx.size(); rd0 = rd_cnt;
    send(8'd5);
    check("busy_on", 64'(busy), 64'd1);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    check("idle_after", 64'(busy), 64'd0);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("nbytes", 64'(rx.size() - r0), 64'd7);
    check("frame1", 64'(pack7(r0)), 64'h05112233445566);
    check("sck_hi_min", 64'(hi_min), 64'd4);
    check("sck_hi_max", 64'(hi_max), 64'd4);
    check("sck_lo_min", 64'(lo_min), 64'd4);
    check("sck_lo_max", 64'(lo_max), 64'd4);
    check("cs_to_sck", 64'(lead), 64'd4);
    check("mosi_stable", 64'(mosi_bad), 64'd0);
    check("pix_reads", 64'(rd_cnt - rd0), 64'd2);
    check("pix_addr_max", 64'(addr_max), 64'd1);
    check("no_err", 64'(err_cnt - e0), 64'd0);

    e0 = err_cnt; f0 = falls; rd0 = rd_cnt; b0 = busy_cnt;
    send(8'd16);
    check("rej_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("rej_err", 64'(err_cnt - e0), 64'd1);
    check("rej_frames", 64'(falls - f0), 64'd0);
    check("rej_rd", 64'(rd_cnt - rd0), 64'd0);
    check("rej_busy_cyc", 64'(busy_cnt - b0), 64'd0);
    check("rej_cs", 64'(sender_cs), 64'd1);

    d0 = done_cnt; e0 = err_cnt; r0 = rx.size();
    send(8'd7);
    for (int i = 0; i < 2000 && rx.size() - r0 < 3; i++) @(negedge clk);
    check("mid_bytes", 64'(rx.size() - r0), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_cs", 64'(sender_cs), 64'd1);
    check("mid_sck", 64'(sender_sck), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_no_done", 64'(done_cnt - d0), 64'd0);
    check("mid_no_err", 64'(err_cnt - e0), 64'd0);

    d0 = done_cnt; r0 = rx.size();
    send(8'd9);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    check("refr_done", 64'(done_cnt - d0), 64'd1);
    check("refr_frame", 64'(pack7(r0)), 64'h09112233445566);

    d0 = done_cnt; f0 = falls; r0 = rx.size();
    @(negedge clk);
    start = 1'b1;
    universe = 8'd3;
    for (int i = 0; i < 2500 && done_cnt - d0 < 2; i++) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("b2b_done", 64'(done_cnt - d0), 64'd2);
    check("b2b_frames", 64'(falls - f0), 64'd2);
    check("b2b_gap_ge16", 64'(last_gap >= 16), 64'd1);
    check("b2b_frame2", 64'(pack7(r0 + 7)), 64'h03112233445566);
    check("b2b_idle", 64'(busy), 64'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
